// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: the controlling FSM drives the
// master side (load/start/pause/abort), the timer drives the slave side.
interface countdown_timer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, start, pause, abort,
    input  count, busy, done
  );

  modport slave (
    input  load, load_val, start, pause, abort,
    output count, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause/abort and a one-cycle done pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic auto-reload instead of one-shot.
module countdown_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  countdown_timer_if.slave    tmr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             done_q;

  // abort outranks every other control in every state, including IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tmr.abort) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (tmr.load) begin
              count_q  <= tmr.load_val;
              reload_q <= tmr.load_val;
            end else if (tmr.start && (count_q != '0)) begin
              state_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (tmr.pause) begin
              state_q <= ST_HOLD;
            end else if (count_q > WIDTH'(1)) begin
              count_q <= count_q - WIDTH'(1);
            end else begin
              // count is never 0 in RUN, so this is the terminal edge at 1
              done_q <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              count_q <= reload_q;
`else
              count_q <= '0;
              state_q <= ST_IDLE;
`endif
            end
          end
          ST_HOLD: begin
            if (!tmr.pause) begin
              state_q <= ST_RUN;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tmr.count = count_q;
  assign tmr.busy  = (state_q != ST_IDLE);
  assign tmr.done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: behavioural model compared every
// cycle, plus hand-computed literal expectations along the directed sequence.
module tb_countdown_timer;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  logic chk_en;
  int   total;
  int   bad;

  countdown_timer_if #(.WIDTH(W)) tif ();

  countdown_timer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .tmr (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: "active" means counting or frozen; "frozen" means paused.
  int m_cnt;
  int m_rel;
  bit m_act;
  bit m_frz;
  bit m_done;

  always @(posedge clk) begin
    if (!rst) begin
      m_cnt = 0; m_rel = 0; m_act = 0; m_frz = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (tif.abort) begin
        m_act = 0; m_frz = 0;
      end else if (!m_act) begin
        if (tif.load) begin
          m_cnt = int'(tif.load_val);
          m_rel = int'(tif.load_val);
        end else if (tif.start && m_cnt != 0) begin
          m_act = 1;
        end
      end else if (m_frz) begin
        if (!tif.pause) m_frz = 0;
      end else if (tif.pause) begin
        m_frz = 1;
      end else if (m_cnt > 1) begin
        m_cnt = m_cnt - 1;
      end else begin
        m_done = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        m_cnt = m_rel;
`else
        m_cnt = 0;
        m_act = 0;
`endif
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_count", int'(tif.count), m_cnt);
      chk("model_busy",  int'(tif.busy),  int'(m_act));
      chk("model_done",  int'(tif.done),  int'(m_done));
    end
  end

  task automatic drv(input logic l, input logic [W-1:0] lv, input logic s,
                     input logic p, input logic a);
    tif.load = l; tif.load_val = lv; tif.start = s; tif.pause = p; tif.abort = a;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string nm, input int c, input int b, input int d);
    chk({nm, "_count"}, int'(tif.count), c);
    chk({nm, "_busy"},  int'(tif.busy),  b);
    chk({nm, "_done"},  int'(tif.done),  d);
  endtask

  initial begin
    total = 0; bad = 0; chk_en = 1'b0;
    rst = 1'b0;
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 chk_en = 1'b1;
    cyc(2);
    lit("reset", 0, 0, 0);

    // start with count 0 is ignored
    rst = 1'b1;
    drv(1'b0, '0, 1'b1, 1'b0, 1'b0); cyc(1);
    lit("start_zero", 0, 0, 0);

    // load/start collision: load wins, stays idle
    drv(1'b1, 4'd4, 1'b0, 1'b0, 1'b0); cyc(1);
    lit("load4", 4, 0, 0);
    drv(1'b1, 4'd7, 1'b1, 1'b0, 1'b0); cyc(1);
    lit("collide", 7, 0, 0);

    // one-shot from 10
    drv(1'b1, 4'd10, 1'b0, 1'b0, 1'b0); cyc(1);
    drv(1'b0, '0, 1'b1, 1'b0, 1'b0); cyc(1);
    lit("os_e0", 10, 1, 0);
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (k < 10) lit("os_step", 10 - k, 1, 0);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
      else lit("os_term", 0, 0, 1);
`endif
    end
    cyc(1);
    chk("os_done_clr", int'(tif.done), 0);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    drv(1'b0, '0, 1'b1, 1'b0, 1'b0); cyc(1);
    lit("os_restart0", 0, 0, 0);
`endif
    drv(1'b0, '0, 1'b0, 1'b0, 1'b1); cyc(1);

    // pause for 3 cycles at count 3
    drv(1'b1, 4'd5, 1'b0, 1'b0, 1'b0); cyc(1);
    drv(1'b0, '0, 1'b1, 1'b0, 1'b0); cyc(1);
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0); cyc(2);
    lit("ps_pre", 3, 1, 0);
    drv(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      lit("ps_hold", 3, 1, 0);
    end
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0); cyc(1);
    lit("ps_resume", 3, 1, 0);
    cyc(1); lit("ps_2", 2, 1, 0);
    cyc(1); lit("ps_1", 1, 1, 0);
    cyc(1);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    lit("ps_term", 0, 0, 1);
`else
    lit("ps_term", 5, 1, 1);
`endif
    drv(1'b0, '0, 1'b0, 1'b0, 1'b1); cyc(1);

    // abort beats load and pause; start resumes from held count
    drv(1'b1, 4'd9, 1'b0, 1'b0, 1'b0); cyc(1);
    drv(1'b0, '0, 1'b1, 1'b0, 1'b0); cyc(1);
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0); cyc(3);
    lit("ab_pre", 6, 1, 0);
    drv(1'b1, 4'd2, 1'b0, 1'b1, 1'b1); cyc(1);
    lit("ab_prio", 6, 0, 0);
    drv(1'b0, '0, 1'b1, 1'b0, 1'b0); cyc(1);
    lit("ab_restart", 6, 1, 0);
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0); cyc(1);
    lit("ab_dec", 5, 1, 0);
    drv(1'b0, '0, 1'b0, 1'b0, 1'b1); cyc(1);
    lit("ab_stop", 5, 0, 0);

    // abort on the terminal edge: no done, count stays 1
    drv(1'b1, 4'd2, 1'b0, 1'b0, 1'b0); cyc(1);
    drv(1'b0, '0, 1'b1, 1'b0, 1'b0); cyc(1);
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0); cyc(1);
    lit("at_pre", 1, 1, 0);
    drv(1'b0, '0, 1'b0, 1'b0, 1'b1); cyc(1);
    lit("at_term", 1, 0, 0);
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0); cyc(1);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // periodic reload from 3, then reset mid-run
    drv(1'b1, 4'd3, 1'b0, 1'b0, 1'b0); cyc(1);
    drv(1'b0, '0, 1'b1, 1'b0, 1'b0); cyc(1);
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      lit("ar_step", 3 - (k % 3), 1, (k % 3 == 0) ? 1 : 0);
    end
    rst = 1'b0; cyc(1);
    lit("ar_reset", 0, 0, 0);
    rst = 1'b1;

    // reload of 1 pulses done every cycle
    drv(1'b1, 4'd1, 1'b0, 1'b0, 1'b0); cyc(1);
    drv(1'b0, '0, 1'b1, 1'b0, 1'b0); cyc(1);
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      lit("ar_one", 1, 1, 1);
    end
    drv(1'b0, '0, 1'b0, 1'b0, 1'b1); cyc(1);
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
`endif

    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
